user_input_ctrl: RTL and testbench
==================================

Name: user_input_ctrl

Overview:
Input-side counterpart of the 7-segment output path: collects a decimal number from the user for the processor's input instruction. Behaviour:
- Debounces three pushbuttons.
- Appends BCD digits taken from SW[3:0].
- On ENTER, delivers the 32-bit value to the datapath with a one-cycle valid pulse.
- Exposes the running entry and digit count so the display block can echo typing.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a key level change is accepted (>=2)
MAX_DIGITS, 8, maximum digits accepted per entry (1..9)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
input_req  input  1  level; high while processor is executing an input instruction
key_digit_n  input  1  raw pushbutton, active-low: append SW digit
key_enter_n  input  1  raw pushbutton, active-low: commit entry
key_clear_n  input  1  raw pushbutton, active-low: clear entry
SW  input  4  BCD digit to append
value  output  32  committed number; held until next commit
value_valid  output  1  one-cycle pulse when value is committed
busy  output  1  high in COLLECT state
entry  output  32  current accumulated number (for display echo)
digit_count  output  4  digits entered so far

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; value=0, value_valid=0, busy=0, entry=0, digit_count=0.
  - Debouncers report released; counters cleared.
- Per-key debouncer:
  - 2-FF synchronizer, then a counter.
  - Debounced level flips only after the synchronized raw level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the counter.
  - Press event = 1-cycle pulse on the debounced released->pressed edge. Exactly one event per physical press; holding a key produces no repeat.
  - Debouncers run in all states.
- FSM states: IDLE, COLLECT, DONE.
  - IDLE: key events ignored. input_req=1 -> COLLECT next cycle, with entry<=0, digit_count<=0.
  - COLLECT (busy=1): event priority when several occur in the same cycle is clear > enter > digit.
    - clear: entry<=0, digit_count<=0, stay in COLLECT.
    - enter: value<=entry, value_valid=1 for exactly the next cycle, -> DONE. Enter with digit_count=0 commits 0.
    - digit: if SW<=9 and digit_count<MAX_DIGITS, then entry<=entry*10+SW and digit_count+1. SW>=10 or digit_count==MAX_DIGITS: event dropped, no change.
    - input_req=0 while in COLLECT: abort -> IDLE, no value_valid, value unchanged, entry retained.
  - DONE: keys ignored; waits for input_req=0, then -> IDLE. Prevents a held request from double-committing.
- Arithmetic: entry*10 computed in 32-bit unsigned. MAX_DIGITS<=9 guarantees no overflow, so no saturation logic is required.
- Latency: raw press to press event = 2 sync + DEBOUNCE_CYCLES cycles. Event to entry/value update = 1 cycle.
- value_valid never asserts outside the COLLECT->DONE transition.

Test Plan (DEBOUNCE_CYCLES=4, MAX_DIGITS=8):
1. Reset released, input_req=1; press digit with SW=1, SW=2, SW=3; press enter -> entry 1,12,123 after each event; value=123, value_valid high exactly 1 cycle; state DONE; busy=0.
2. key_digit_n toggles every 2 cycles for 20 cycles, then held low 10 cycles with SW=7 -> exactly one digit event; entry=7, digit_count=1.
3. Enter 9 digits of SW=9 -> entry=99999999, digit_count=8; 9th press dropped. Separately, SW=12 pressed -> no change.
4. Entry at 45, clear and digit events in same cycle -> entry=0, digit_count=0. Then enter and digit in same cycle -> value=0, value_valid pulse.
5. Entry at 56, input_req dropped before enter -> IDLE, no value_valid, value keeps previous commit. input_req held high through DONE with enter pressed again -> no second value_valid.
6. reset pulled low mid-COLLECT with entry=321 -> all outputs 0 asynchronously; after release, key events are ignored until input_req rises.

Source files
------------

// File: rtl/user_input_ctrl.sv
// Decimal number entry for the processor's input instruction.
// Three debounced pushbuttons (digit / enter / clear) build a BCD-typed
// number from SW[3:0]. ENTER commits it to the datapath with a one-cycle
// valid pulse. The running entry and digit count are exposed for display echo.

// Debouncer for one active-low pushbutton. It produces a one-cycle press pulse
// on the accepted released->pressed edge.
module user_input_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer. The key is inverted here, so 1 means pressed from this point on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= ~key_n;
      sync_p1 <= sync_p0;
    end
  end

  // Accept a new level only after it has disagreed with the current one for
  // DEBOUNCE_CYCLES consecutive cycles. Any return to the old level restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
        press <= sync_p1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

module user_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MAX_DIGITS      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        input_req,
  input  logic        key_digit_n,
  input  logic        key_enter_n,
  input  logic        key_clear_n,
  input  logic [3:0]  SW,
  output logic [31:0] value,
  output logic        value_valid,
  output logic        busy,
  output logic [31:0] entry,
  output logic [3:0]  digit_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  state_t state;
  logic   ev_digit;
  logic   ev_enter;
  logic   ev_clear;
  logic   digit_ok;

  // Shift one decimal digit into the accumulated number. With at most 9 digits,
  // the result stays below 2^32, so no saturation is needed.
  function automatic logic [31:0] append_digit(input logic [31:0] acc,
                                               input logic [3:0]  d);
    return acc * 32'd10 + {28'd0, d};
  endfunction

  user_input_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_digit (
    .clk   (clk),
    .reset (reset),
    .key_n (key_digit_n),
    .press (ev_digit)
  );

  user_input_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .clk   (clk),
    .reset (reset),
    .key_n (key_enter_n),
    .press (ev_enter)
  );

  user_input_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk   (clk),
    .reset (reset),
    .key_n (key_clear_n),
    .press (ev_clear)
  );

  // A digit is taken only if it is valid BCD and there is still room for it.
  assign digit_ok = (SW <= 4'd9) && (digit_count < MAX_CNT);

  // Entry FSM. Losing the request takes precedence over any key event in the
  // same cycle, because nobody is waiting for the value any more.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      value       <= '0;
      value_valid <= 1'b0;
      busy        <= 1'b0;
      entry       <= '0;
      digit_count <= '0;
    end else begin
      value_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (input_req) begin
            state       <= COLLECT;
            busy        <= 1'b1;
            entry       <= '0;
            digit_count <= '0;
          end
        end
        COLLECT: begin
          if (!input_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (ev_clear) begin
            entry       <= '0;
            digit_count <= '0;
          end else if (ev_enter) begin
            value       <= entry;
            value_valid <= 1'b1;
            state       <= DONE;
            busy        <= 1'b0;
          end else if (ev_digit && digit_ok) begin
            entry       <= append_digit(entry, SW);
            digit_count <= digit_count + 4'd1;
          end
        end
        DONE: begin
          // Hold here until the request drops, so a lingering request cannot commit twice.
          if (!input_req) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_user_input_ctrl.sv
// Self-checking bench for user_input_ctrl. It uses a digit-list reference model at key-press granularity.
module tb_user_input_ctrl;

  localparam int DC = 4;
  localparam int MD = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        input_req = 1'b0;
  logic        key_digit_n = 1'b1;
  logic        key_enter_n = 1'b1;
  logic        key_clear_n = 1'b1;
  logic [3:0]  SW = 4'd0;
  logic [31:0] value;
  logic        value_valid;
  logic        busy;
  logic [31:0] entry;
  logic [3:0]  digit_count;

  int n_checks = 0;
  int n_pass   = 0;
  int vv_count = 0;

  always #5 clk = ~clk;

  user_input_ctrl #(.DEBOUNCE_CYCLES(DC), .MAX_DIGITS(MD)) dut (
    .clk         (clk),
    .reset       (reset),
    .input_req   (input_req),
    .key_digit_n (key_digit_n),
    .key_enter_n (key_enter_n),
    .key_clear_n (key_clear_n),
    .SW          (SW),
    .value       (value),
    .value_valid (value_valid),
    .busy        (busy),
    .entry       (entry),
    .digit_count (digit_count)
  );

  // Every cycle with value_valid high is counted, so a stretched pulse shows up as a count above 1.
  always @(negedge clk) if (value_valid === 1'b1) vv_count++;

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_COLLECT, M_DONE} mstate_t;
  mstate_t     m_state = M_IDLE;
  int unsigned m_digits[$];
  logic [31:0] m_value = 32'd0;
  int          m_exp_pulses = 0;

  function automatic logic [31:0] m_entry();
    logic [31:0] r;
    r = 32'd0;
    foreach (m_digits[i]) r = r * 32'd10 + 32'(m_digits[i]);
    return r;
  endfunction

  function automatic logic [3:0] m_count();
    return 4'(m_digits.size());
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_digits.delete();
    m_value = 32'd0;
    m_exp_pulses = 0;
  endtask

  task automatic model_keys(input bit kd, input bit ke, input bit kc, input int sw);
    m_exp_pulses = 0;
    if (m_state == M_COLLECT) begin
      if (kc) m_digits.delete();
      else if (ke) begin
        m_value = m_entry();
        m_exp_pulses = 1;
        m_state = M_DONE;
      end else if (kd && sw <= 9 && m_digits.size() < MD) m_digits.push_back(sw);
    end
  endtask

  task automatic model_req(input bit r);
    m_exp_pulses = 0;
    if (m_state == M_IDLE && r) begin
      m_state = M_COLLECT;
      m_digits.delete();
    end else if (m_state != M_IDLE && !r) begin
      m_state = M_IDLE;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit kd, input bit ke, input bit kc, input logic [3:0] sw,
                       output int pulses);
    int start;
    start = vv_count;
    SW = sw;
    if (kd) key_digit_n = 1'b0;
    if (ke) key_enter_n = 1'b0;
    if (kc) key_clear_n = 1'b0;
    repeat (DC + 5) tick();
    key_digit_n = 1'b1;
    key_enter_n = 1'b1;
    key_clear_n = 1'b1;
    repeat (DC + 5) tick();
    pulses = vv_count - start;
    model_keys(kd, ke, kc, int'(sw));
  endtask

  task automatic set_req(input bit r, output int pulses);
    int start;
    start = vv_count;
    input_req = r;
    repeat (3) tick();
    pulses = vv_count - start;
    model_req(r);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int p;
    reset = 1'b0;
    repeat (3) tick();
    n_checks++; if (value !== 32'd0) $display("FAIL reset_value got %0d want 0", value); else n_pass++;
    n_checks++; if (value_valid !== 1'b0) $display("FAIL reset_vv got %b want 0", value_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (entry !== 32'd0) $display("FAIL reset_entry got %0d want 0", entry); else n_pass++;
    n_checks++; if (digit_count !== 4'd0) $display("FAIL reset_count got %0d want 0", digit_count); else n_pass++;
    reset = 1'b1;
    model_reset();
    tick();
    // Key presses made before the request arrives are ignored.
    press(1'b1, 1'b0, 1'b0, 4'd6, p);
    n_checks++; if (entry !== 32'd0) $display("FAIL idle_key_entry got %0d want 0", entry); else n_pass++;
  endtask

  task automatic test_basic_entry();
    int p;
    logic [31:0] exp_e[3];
    exp_e[0] = 32'd1; exp_e[1] = 32'd12; exp_e[2] = 32'd123;
    set_req(1'b1, p);
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy_collect got %b want 1", busy); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      press(1'b1, 1'b0, 1'b0, 4'(i + 1), p);
      n_checks++; if (entry !== exp_e[i]) $display("FAIL basic_entry%0d got %0d want %0d", i, entry, exp_e[i]); else n_pass++;
      n_checks++; if (digit_count !== 4'(i + 1)) $display("FAIL basic_count%0d got %0d want %0d", i, digit_count, i + 1); else n_pass++;
    end
    press(1'b0, 1'b1, 1'b0, 4'd0, p);
    n_checks++; if (value !== 32'd123) $display("FAIL basic_value got %0d want 123", value); else n_pass++;
    n_checks++; if (p !== 1) $display("FAIL basic_vv_cycles got %0d want 1", p); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_done got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_bounce();
    int p;
    set_req(1'b0, p);
    set_req(1'b1, p);
    SW = 4'd7;
    for (int i = 0; i < 10; i++) begin
      key_digit_n = ~key_digit_n;
      repeat (2) tick();
    end
    key_digit_n = 1'b0;
    repeat (10) tick();
    key_digit_n = 1'b1;
    repeat (DC + 5) tick();
    model_keys(1'b1, 1'b0, 1'b0, 7);
    n_checks++; if (entry !== 32'd7) $display("FAIL bounce_entry got %0d want 7", entry); else n_pass++;
    n_checks++; if (digit_count !== 4'd1) $display("FAIL bounce_count got %0d want 1", digit_count); else n_pass++;
  endtask

  task automatic test_max_digits();
    int p;
    press(1'b0, 1'b0, 1'b1, 4'd0, p);
    for (int i = 0; i < 9; i++) press(1'b1, 1'b0, 1'b0, 4'd9, p);
    n_checks++; if (entry !== 32'd99999999) $display("FAIL max_entry got %0d want 99999999", entry); else n_pass++;
    n_checks++; if (digit_count !== 4'd8) $display("FAIL max_count got %0d want 8", digit_count); else n_pass++;
    press(1'b0, 1'b0, 1'b1, 4'd0, p);
    press(1'b1, 1'b0, 1'b0, 4'd5, p);
    press(1'b1, 1'b0, 1'b0, 4'd12, p);
    n_checks++; if (entry !== 32'd5) $display("FAIL nonbcd_entry got %0d want 5", entry); else n_pass++;
    n_checks++; if (digit_count !== 4'd1) $display("FAIL nonbcd_count got %0d want 1", digit_count); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int p;
    press(1'b0, 1'b0, 1'b1, 4'd0, p);
    press(1'b1, 1'b0, 1'b0, 4'd4, p);
    press(1'b1, 1'b0, 1'b0, 4'd5, p);
    n_checks++; if (entry !== 32'd45) $display("FAIL sim_entry45 got %0d want 45", entry); else n_pass++;
    press(1'b1, 1'b0, 1'b1, 4'd3, p);
    n_checks++; if (entry !== 32'd0) $display("FAIL sim_clear_entry got %0d want 0", entry); else n_pass++;
    n_checks++; if (digit_count !== 4'd0) $display("FAIL sim_clear_count got %0d want 0", digit_count); else n_pass++;
    press(1'b1, 1'b1, 1'b0, 4'd3, p);
    n_checks++; if (value !== 32'd0) $display("FAIL sim_enter_value got %0d want 0", value); else n_pass++;
    n_checks++; if (p !== 1) $display("FAIL sim_enter_vv got %0d want 1", p); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL sim_enter_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_abort();
    int p;
    set_req(1'b0, p);
    set_req(1'b1, p);
    press(1'b1, 1'b0, 1'b0, 4'd7, p);
    press(1'b0, 1'b1, 1'b0, 4'd0, p);
    n_checks++; if (value !== 32'd7) $display("FAIL abort_commit7 got %0d want 7", value); else n_pass++;
    press(1'b0, 1'b1, 1'b0, 4'd0, p);
    n_checks++; if (p !== 0) $display("FAIL done_reenter_vv got %0d want 0", p); else n_pass++;
    set_req(1'b0, p);
    set_req(1'b1, p);
    press(1'b1, 1'b0, 1'b0, 4'd5, p);
    press(1'b1, 1'b0, 1'b0, 4'd6, p);
    n_checks++; if (entry !== 32'd56) $display("FAIL abort_entry56 got %0d want 56", entry); else n_pass++;
    set_req(1'b0, p);
    n_checks++; if (p !== 0) $display("FAIL abort_vv got %0d want 0", p); else n_pass++;
    n_checks++; if (value !== 32'd7) $display("FAIL abort_value got %0d want 7", value); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (entry !== 32'd56) $display("FAIL abort_retain got %0d want 56", entry); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int p;
    set_req(1'b1, p);
    press(1'b1, 1'b0, 1'b0, 4'd3, p);
    press(1'b1, 1'b0, 1'b0, 4'd2, p);
    press(1'b1, 1'b0, 1'b0, 4'd1, p);
    n_checks++; if (entry !== 32'd321) $display("FAIL rmid_entry got %0d want 321", entry); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (entry !== 32'd0) $display("FAIL rmid_async_entry got %0d want 0", entry); else n_pass++;
    n_checks++; if (value !== 32'd0) $display("FAIL rmid_async_value got %0d want 0", value); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_async_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (digit_count !== 4'd0) $display("FAIL rmid_async_count got %0d want 0", digit_count); else n_pass++;
    input_req = 1'b0;
    model_reset();
    tick();
    reset = 1'b1;
    tick();
    press(1'b1, 1'b0, 1'b0, 4'd4, p);
    n_checks++; if (entry !== 32'd0) $display("FAIL rmid_idle_entry got %0d want 0", entry); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_idle_busy got %b want 0", busy); else n_pass++;
    set_req(1'b1, p);
    press(1'b1, 1'b0, 1'b0, 4'd4, p);
    n_checks++; if (entry !== 32'd4) $display("FAIL rmid_after_entry got %0d want 4", entry); else n_pass++;
  endtask

  task automatic test_random();
    int p;
    int op;
    bit kd, ke, kc;
    logic [3:0] sw;
    for (int it = 0; it < 50; it++) begin
      op = int'($urandom_range(0, 9));
      sw = 4'($urandom_range(0, 15));
      if (op <= 1) begin
        set_req($urandom_range(0, 3) != 0, p);
      end else begin
        kd = (op <= 5) || (op == 9);
        ke = (op == 6);
        kc = (op == 7);
        if (op == 8) begin
          kd = 1'($urandom_range(0, 1));
          ke = 1'($urandom_range(0, 1));
          kc = 1'($urandom_range(0, 1));
        end
        if (op == 9) sw = 4'd9;
        press(kd, ke, kc, sw, p);
      end
      n_checks++; if (entry !== m_entry()) $display("FAIL rnd%0d_entry got %0d want %0d", it, entry, m_entry()); else n_pass++;
      n_checks++; if (digit_count !== m_count()) $display("FAIL rnd%0d_count got %0d want %0d", it, digit_count, m_count()); else n_pass++;
      n_checks++; if (value !== m_value) $display("FAIL rnd%0d_value got %0d want %0d", it, value, m_value); else n_pass++;
      n_checks++; if (busy !== (m_state == M_COLLECT)) $display("FAIL rnd%0d_busy got %b want %b", it, busy, m_state == M_COLLECT); else n_pass++;
      n_checks++; if (p !== m_exp_pulses) $display("FAIL rnd%0d_vv got %0d want %0d", it, p, m_exp_pulses); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_entry();
    test_bounce();
    test_max_digits();
    test_simultaneous();
    test_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
